// File: rtl/datapath.sv
// Accumulator-machine datapath: PC, IR, accumulator, 16x8 register file, ALU/shifter, Z/C flags.
// Define DATAPATH_RF_CLEAR_EN to have the synchronous reset also clear the register file.
module datapath (
  input  logic        clk,
  input  logic        CLB,
  input  logic        LoadIR,
  input  logic        IncPC,
  input  logic        SelPC,
  input  logic        LoadPC,
  input  logic        LoadReg,
  input  logic        LoadAcc,
  input  logic [1:0]  SelAcc,
  input  logic [3:0]  SelALU,
  input  logic [11:0] InstrData,
  output logic [7:0]  InstrAddr,
  output logic [3:0]  Opcode,
  output logic        Z,
  output logic        C,
  output logic [7:0]  AccOut
);

  logic [7:0]  pc_q, pc_d;
  logic [11:0] ir_q, ir_d;
  logic [7:0]  acc_q, acc_d;
  logic        z_q, z_d;
  logic        c_q, c_d;
  logic [7:0]  rf_q [16];
  logic [7:0]  rf_d [16];

  logic [3:0]  rf_idx;
  logic [7:0]  rf_rdata;
  logic [7:0]  imm;
  logic [8:0]  alu_res;

  assign rf_idx   = ir_q[3:0];
  assign rf_rdata = rf_q[rf_idx];
  assign imm      = ir_q[7:0];

  // Bit 8 carries C for every operation: carry, borrow, shifted-out bit, or 0.
  always_comb begin
    alu_res = 9'd0;
    case (SelALU[3:2])
      2'b00: begin
        case (SelALU[1:0])
          2'b01:   alu_res = {acc_q, 1'b0};
          2'b11:   alu_res = {acc_q[0], 1'b0, acc_q[7:1]};
          default: alu_res = {1'b0, acc_q};
        endcase
      end
      2'b01:   alu_res = {1'b0, ~(acc_q | rf_rdata)};
      2'b10:   alu_res = {1'b0, acc_q} + {1'b0, rf_rdata};
      default: alu_res = {1'b0, acc_q} - {1'b0, rf_rdata};
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (LoadPC) begin
      pc_d = SelPC ? rf_rdata : imm;
    end else if (IncPC) begin
      pc_d = pc_q + 8'd1;
    end

    ir_d = LoadIR ? InstrData : ir_q;

    acc_d = acc_q;
    z_d   = z_q;
    c_d   = c_q;
    if (LoadAcc) begin
      case (SelAcc)
        2'b00: begin
          acc_d = alu_res[7:0];
          z_d   = (alu_res[7:0] == 8'd0);
          c_d   = alu_res[8];
        end
        2'b01:   acc_d = rf_rdata;
        2'b10:   acc_d = imm;
        default: acc_d = acc_q;
      endcase
    end
  end

  // Reset suppresses the write so the file is untouched by a reset cycle.
  always_comb begin
    rf_d = rf_q;
    if (LoadReg && !CLB) begin
      rf_d[rf_idx] = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (CLB) begin
      pc_q  <= 8'd0;
      ir_q  <= 12'd0;
      acc_q <= 8'd0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      acc_q <= acc_d;
      z_q   <= z_d;
      c_q   <= c_d;
    end
  end

`ifdef DATAPATH_RF_CLEAR_EN
  always_ff @(posedge clk) begin
    if (CLB) begin
      rf_q <= '{default: 8'd0};
    end else begin
      rf_q <= rf_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end
`endif

  assign InstrAddr = pc_q;
  assign Opcode    = ir_q[11:8];
  assign Z         = z_q;
  assign C         = c_q;
  assign AccOut    = acc_q;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: directed scenarios plus random strobes against a behavioural model.
module tb_datapath;

  logic        clk = 1'b0;
  logic        CLB, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0]  SelAcc;
  logic [3:0]  SelALU;
  logic [11:0] InstrData;
  logic [7:0]  InstrAddr, AccOut;
  logic [3:0]  Opcode;
  logic        Z, C;

  always #5 clk = ~clk;

  datapath dut (
    .clk       (clk),
    .CLB       (CLB),
    .LoadIR    (LoadIR),
    .IncPC     (IncPC),
    .SelPC     (SelPC),
    .LoadPC    (LoadPC),
    .LoadReg   (LoadReg),
    .LoadAcc   (LoadAcc),
    .SelAcc    (SelAcc),
    .SelALU    (SelALU),
    .InstrData (InstrData),
    .InstrAddr (InstrAddr),
    .Opcode    (Opcode),
    .Z         (Z),
    .C         (C),
    .AccOut    (AccOut)
  );

  logic [11:0] rom [256];
  assign InstrData = rom[InstrAddr];

  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] op;
    logic [7:0] acc;
    logic       z;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference machine state
  logic [7:0]  m_pc, m_acc;
  logic [11:0] m_ir;
  logic        m_z, m_c;
  logic [7:0]  m_rf [16];

  task automatic model_step(input logic lir, ipc, spc, lpc, lreg, lacc,
                            input logic [1:0] sacc, input logic [3:0] salu, input logic rst);
    int a, b, r, npc;
    bit cy;
    logic [7:0] imm;
    logic [3:0] idx;
    if (rst) begin
      m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
`ifdef DATAPATH_RF_CLEAR_EN
      for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
`endif
      return;
    end
    idx = m_ir[3:0];
    imm = m_ir[7:0];
    a = int'(m_acc);
    b = int'(m_rf[idx]);
    r = 0; cy = 0;
    case (salu[3:2])
      2'd0: begin
        if (salu[1:0] == 2'b01)      begin r = (a * 2) % 256; cy = (a >= 128); end
        else if (salu[1:0] == 2'b11) begin r = a / 2;         cy = (a % 2) == 1; end
        else                         begin r = a;             cy = 0; end
      end
      2'd1: begin r = 255 - (a | b); cy = 0; end
      2'd2: begin r = (a + b) % 256; cy = (a + b) > 255; end
      default: begin r = (a - b + 256) % 256; cy = (a < b); end
    endcase
    npc = int'(m_pc);
    if (lpc) npc = spc ? b : int'(imm);
    else if (ipc) npc = (npc + 1) % 256;
    if (lir) m_ir = rom[m_pc];
    if (lreg) m_rf[idx] = m_acc;
    if (lacc) begin
      if (sacc == 2'b00) begin m_acc = 8'(r); m_z = (r == 0); m_c = cy; end
      else if (sacc == 2'b01) m_acc = 8'(b);
      else if (sacc == 2'b10) m_acc = imm;
    end
    m_pc = 8'(npc);
  endtask

  task automatic cyc(input logic lir, ipc, spc, lpc, lreg, lacc,
                     input logic [1:0] sacc, input logic [3:0] salu, input logic rst);
    exp_t e;
    @(negedge clk);
    CLB = rst; LoadIR = lir; IncPC = ipc; SelPC = spc; LoadPC = lpc;
    LoadReg = lreg; LoadAcc = lacc; SelAcc = sacc; SelALU = salu;
    model_step(lir, ipc, spc, lpc, lreg, lacc, sacc, salu, rst);
    e.pc = m_pc; e.op = m_ir[11:8]; e.acc = m_acc; e.z = m_z; e.c = m_c;
    sb.push_back(e);
  endtask

  task automatic load_ir(input logic [11:0] w);
    rom[m_pc] = w;
    cyc(1, 1, 0, 0, 0, 0, 2'b11, 4'd0, 0);
  endtask

  task automatic set_acc(input logic [7:0] v);
    load_ir({4'hD, v});
    cyc(0, 0, 0, 0, 0, 1, 2'b10, 4'd0, 0);
  endtask

  task automatic set_reg(input logic [3:0] i, input logic [7:0] v);
    set_acc(v);
    load_ir({4'h5, 4'h0, i});
    cyc(0, 0, 0, 0, 1, 0, 2'b11, 4'd0, 0);
  endtask

  task automatic alu_op(input logic [3:0] i, input logic [3:0] salu);
    load_ir({4'h8, 4'h0, i});
    cyc(0, 0, 0, 0, 0, 1, 2'b00, salu, 0);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs after each sampled edge are compared with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc",     InstrAddr,        e.pc);
        chk("opcode", {4'h0, Opcode},   {4'h0, e.op});
        chk("acc",    AccOut,           e.acc);
        chk("z",      {7'd0, Z},        {7'd0, e.z});
        chk("c",      {7'd0, C},        {7'd0, e.c});
      end
    end
  end

  initial begin
    CLB = 1; LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0;
    LoadReg = 0; LoadAcc = 0; SelAcc = 0; SelALU = 0;
    for (int i = 0; i < 256; i++) rom[i] = 12'($urandom);
    for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;

    // Reset with random strobes
    repeat (2) cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 2'($urandom), 4'($urandom), 1);
`ifdef DATAPATH_RF_CLEAR_EN
    load_ir(12'h405);
    cyc(0, 0, 0, 0, 0, 1, 2'b01, 4'd0, 0);
`endif

    // Give every register a known value
    for (int i = 0; i < 16; i++) set_reg(4'(i), 8'($urandom));

    // Load / store
    set_acc(8'hF0);
    load_ir(12'h503);
    cyc(0, 0, 0, 0, 1, 0, 2'b11, 4'd0, 0);
    set_acc(8'h00);
    load_ir(12'h403);
    cyc(0, 0, 0, 0, 0, 1, 2'b01, 4'd0, 0);

    // Arithmetic flags
    set_reg(4'd3, 8'h10); set_acc(8'hF0); alu_op(4'd3, 4'b1000);
    set_reg(4'd3, 8'h07); set_acc(8'h05); alu_op(4'd3, 4'b1100);
    set_reg(4'd3, 8'hF0); set_acc(8'h0F); alu_op(4'd3, 4'b0100);

    // Shifts, including ignored shift bits on a non-pass op
    set_acc(8'h81); alu_op(4'd3, 4'b0001); alu_op(4'd3, 4'b0011); alu_op(4'd3, 4'b0010);
    alu_op(4'd3, 4'b1001);

    // PC control: wrap, LoadPC priority, register source
    load_ir(12'h7FF);
    cyc(0, 0, 0, 1, 0, 0, 2'b11, 4'd0, 0);
    cyc(0, 1, 0, 0, 0, 0, 2'b11, 4'd0, 0);
    load_ir(12'h742);
    cyc(0, 1, 0, 1, 0, 0, 2'b11, 4'd0, 0);
    set_reg(4'd2, 8'h10);
    load_ir(12'h602);
    cyc(0, 0, 1, 1, 0, 0, 2'b11, 4'd0, 0);

    // Simultaneous events
    set_acc(8'h11);
    load_ir(12'hD22);
    cyc(0, 0, 0, 0, 1, 1, 2'b10, 4'd0, 0);
    load_ir(12'h402);
    cyc(0, 0, 0, 0, 0, 1, 2'b01, 4'd0, 0);
    set_reg(4'd4, 8'hAA); set_acc(8'h55);
    load_ir(12'h604);
    cyc(0, 0, 1, 1, 1, 0, 2'b11, 4'd0, 0);
    cyc(1, 0, 0, 1, 0, 0, 2'b11, 4'd0, 0);
    set_reg(4'd2, 8'h33); set_acc(8'h11);
    load_ir(12'hD22);
    cyc(1, 1, 1, 1, 1, 1, 2'b10, 4'd0, 1);
    load_ir(12'h402);
    cyc(0, 0, 0, 0, 0, 1, 2'b01, 4'd0, 0);

    // Random strobes with occasional reset
    for (int n = 0; n < 2000; n++) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 2'($urandom), 4'($urandom), $urandom_range(0, 39) == 0);
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath.md
# datapath

Accumulator-machine datapath driven by `controller`: holds the PC, IR, 8-bit accumulator, 16×8 register file, ALU/shifter and the Z/C flags. It executes the per-cycle load/select strobes issued by the controller. It returns Opcode, Z and C to close the control loop. It fetches 12-bit instructions from an external combinational program ROM addressed by the PC.

## Interface
Parameters:
- none (data 8 bits, instruction 12 bits, 16 registers, all fixed)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- CLB  in  1  reset, synchronous, active-high
- LoadIR  in  1  IR <= InstrData
- IncPC  in  1  PC <= PC+1
- SelPC  in  1  PC load source: 1 = Reg[IR[3:0]], 0 = IR[7:0]
- LoadPC  in  1  PC <= selected source
- LoadReg  in  1  Reg[IR[3:0]] <= Acc
- LoadAcc  in  1  Acc <= SelAcc source
- SelAcc  in  2  00 ALU result, 01 Reg[IR[3:0]], 10 IR[7:0], 11 hold
- SelALU  in  4  [3:2] op: 00 pass/shift, 01 NOR, 10 ADD, 11 SUB; [1:0] shift: 00 none, 01 left, 11 right, 10 none
- InstrData  in  12  ROM word at InstrAddr
- InstrAddr  out  8  current PC
- Opcode  out  4  IR[11:8]
- Z  out  1  zero flag
- C  out  1  carry/borrow/shift-out flag
- AccOut  out  8  accumulator value

## Operation
- Instruction fields: IR[11:8] opcode, IR[7:0] immediate, IR[3:0] register index (rs/rd).
- ALU operand A = Acc, B = Reg[IR[3:0]]. Results, 9-bit internal:
  - ADD: A+B; C = bit 8.
  - SUB: A−B; C = 1 iff A < B (borrow).
  - NOR: ~(A|B); C = 0.
  - Op 00 with shift 01: A<<1, C = A[7]. Shift 11: A>>1 logical, C = A[0]. Shift 00/10: pass A, C = 0.
  - Shift bits are ignored when op ≠ 00.
- Flags update only when LoadAcc=1 and SelAcc=00: Z = (result[7:0]==0), C as above. Otherwise Z/C hold, including for SelAcc 01/10 loads.
- PC:
  - LoadPC has priority over IncPC.
  - IncPC wraps 0xFF→0x00.
  - Neither asserted: hold.
- SelAcc=11 with LoadAcc=1: Acc holds, flags hold.
- Register file: one write port, two combinational reads (ALU/SelAcc path and PC path share index IR[3:0]).
- Simultaneous events, all sample pre-edge values:
  - LoadReg+LoadAcc: register receives old Acc.
  - LoadIR+LoadPC: IR receives word at old PC.
  - LoadReg and SelPC=1 on the same index: PC gets old register value.
- Opcode 1111 (HALT): the controller drives all strobes low, so the datapath holds all state.

## Timing
- Reset (CLB=1 at edge): PC=0x00, IR=0x000 (Opcode=0000), Acc=0x00, Z=0, C=0. Outputs are valid the cycle after the edge. Reset overrides every strobe, mid-instruction included.
- All outputs are registered or derived purely from registers: InstrAddr=PC, Opcode=IR[11:8], AccOut=Acc, Z, C. None has a combinational path from the strobe inputs.
- InstrData is sampled in the same cycle InstrAddr presents; the ROM is zero-latency.
- Strobe effects are visible one cycle after the edge on which they are sampled.
- With the controller's two-phase sequence (LoadIR cycle, then execute cycle), each instruction takes 2 cycles. Opcode changes the cycle after LoadIR.

## Configuration
- DATAPATH_RF_CLEAR_EN defined: synchronous reset also clears all 16 registers to 0x00.
- Undefined: the register file has no reset; contents persist across CLB, and values are X before the first write in simulation. All other reset behaviour is unchanged.

## Test plan
- Reset: hold CLB=1 for 2 cycles with random strobes -> PC=0, Opcode=0, Acc=0, Z=0, C=0. With DATAPATH_RF_CLEAR_EN, Reg[5] reads 0x00.
- Load/store: IR=0xD_0F0, LoadAcc SelAcc=10 -> Acc=0xF0. Then IR=0x5_003, LoadReg -> Reg[3]=0xF0. Then IR=0x4_003 after Acc cleared, SelAcc=01 -> Acc=0xF0, Z/C unchanged.
- Arithmetic flags:
  - Acc=0xF0, Reg[3]=0x10, ADD -> Acc=0x00, Z=1, C=1.
  - Acc=0x05, Reg[3]=0x07, SUB -> Acc=0xFE, Z=0, C=1.
  - Acc=0x0F, Reg[3]=0xF0, NOR -> Acc=0x00, Z=1, C=0.
- Shifts: Acc=0x81, SelALU=0001 -> Acc=0x02, C=1. Then SelALU=0011 -> Acc=0x01, C=0.
- PC control:
  - PC=0xFF, IncPC -> 0x00.
  - IR=0x7_042, LoadPC+IncPC, SelPC=0 -> PC=0x42.
  - Reg[2]=0x10, IR=0x6_002, SelPC=1, LoadPC -> PC=0x10.
- Simultaneous: Acc=0x11, LoadReg+LoadAcc (SelAcc=10, IR[7:0]=0x22, IR[3:0]=2) -> Reg[2]=0x11, Acc=0x22. Assert CLB during this cycle -> reset values win and Reg[2] is unchanged.
